// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU controller: opcodes, mux selects,
// ALU operations and the FSM state enumeration.
package cpu_ctrl_pkg;

    // Opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation selects
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU B-operand selects
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_ERROR  = 4'd13
    } state_e;

    // States that hold a memory request open and wait for Mem_ack_i
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/op_dispatch.sv
// Combinational opcode decode: picks the state that follows DECODE and tells
// MEMADR whether the memory access is a store.
module op_dispatch
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    output state_e     decode_nxt_o,
    output logic       illegal_o,
    output logic       store_o
);

    // Opcode to successor-state table; unknown opcodes trap to ERROR
    always_comb begin
        decode_nxt_o = S_ERROR;
        illegal_o    = 1'b0;
        store_o      = (op_i == OP_SW);
        case (op_i)
            OP_RTYPE:      decode_nxt_o = S_EXEC;
            OP_ADDI:       decode_nxt_o = S_IEXEC;
            OP_LW, OP_SW:  decode_nxt_o = S_MEMADR;
            OP_BEQ:        decode_nxt_o = S_BRANCH;
            OP_J:          decode_nxt_o = S_JUMP;
            default: begin
                decode_nxt_o = S_ERROR;
                illegal_o    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM with memory-wait timeout and sticky error flags.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] Op_i,
    input  logic       Mem_ack_i,
    output logic       PCWr_o,
    output logic       PCWrCond_o,
    output logic       IorD_o,
    output logic       MemRd_o,
    output logic       MemWr_o,
    output logic       IRWr_o,
    output logic       MemtoReg_o,
    output logic       RegWr_o,
    output logic       RegDst_o,
    output logic       ALUSrcA_o,
    output logic [1:0] PCSrc_o,
    output logic [1:0] ALUSrcB_o,
    output logic [1:0] ALUOp_o,
    output logic       Retire_o,
    output logic       Illegal_o,
    output logic       Timeout_o,
    output logic [3:0] State_o
);

    // A zero timeout still needs a 1-bit counter so the logic stays legal
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] TMO_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          illegal_q, illegal_d;
    logic          timeout_q, timeout_d;

    state_e        dec_nxt;
    logic          dec_illegal;
    logic          dec_store;
    logic          tmo_hit;
    logic          ack;

    op_dispatch u_dispatch (
        .op_i         (Op_i),
        .decode_nxt_o (dec_nxt),
        .illegal_o    (dec_illegal),
        .store_o      (dec_store)
    );

    // Ack only matters while a memory request is outstanding
    assign ack     = Mem_ack_i && is_wait_state(state_q);
    assign tmo_hit = (MEM_TIMEOUT != 0) && (cnt_q == TMO_LAST) && !ack;
    assign State_o   = state_q;
    assign Illegal_o = illegal_q;
    assign Timeout_o = timeout_q;

    // State, wait counter and sticky flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Counter restarts on every state change, counts unacked wait cycles, saturates
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if (is_wait_state(state_q) && !ack && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + 1'b1;
    end

    // Next state and Moore outputs (FETCH/MEMWR also qualify a few outputs with ack)
    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        PCWr_o     = 1'b0;
        PCWrCond_o = 1'b0;
        IorD_o     = 1'b0;
        MemRd_o    = 1'b0;
        MemWr_o    = 1'b0;
        IRWr_o     = 1'b0;
        MemtoReg_o = 1'b0;
        RegWr_o    = 1'b0;
        RegDst_o   = 1'b0;
        ALUSrcA_o  = 1'b0;
        PCSrc_o    = PCSRC_ALU;
        ALUSrcB_o  = SRCB_REG;
        ALUOp_o    = ALUOP_ADD;
        Retire_o   = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                MemRd_o   = 1'b1;
                ALUSrcB_o = SRCB_FOUR;
                if (ack) begin
                    IRWr_o  = 1'b1;
                    PCWr_o  = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d   = S_ERROR;
                    timeout_d = 1'b1;
                end
            end
            S_DECODE: begin
                ALUSrcB_o = SRCB_IMMSH;
                state_d   = dec_nxt;
                if (dec_illegal) illegal_d = 1'b1;
            end
            S_MEMADR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = SRCB_IMM;
                state_d   = dec_store ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRd_o = 1'b1;
                IorD_o  = 1'b1;
                if (ack) begin
                    state_d = S_MEMWB;
                end else if (tmo_hit) begin
                    state_d   = S_ERROR;
                    timeout_d = 1'b1;
                end
            end
            S_MEMWB: begin
                MemtoReg_o = 1'b1;
                RegWr_o    = 1'b1;
                Retire_o   = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                MemWr_o = 1'b1;
                IorD_o  = 1'b1;
                if (ack) begin
                    Retire_o = 1'b1;
                    state_d  = S_FETCH;
                end else if (tmo_hit) begin
                    state_d   = S_ERROR;
                    timeout_d = 1'b1;
                end
            end
            S_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = ALUOP_FUNCT;
                state_d   = S_RWB;
            end
            S_RWB: begin
                RegDst_o = 1'b1;
                RegWr_o  = 1'b1;
                Retire_o = 1'b1;
                state_d  = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = SRCB_IMM;
                state_d   = S_IWB;
            end
            S_IWB: begin
                RegWr_o  = 1'b1;
                Retire_o = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA_o  = 1'b1;
                ALUOp_o    = ALUOP_SUB;
                PCWrCond_o = 1'b1;
                PCSrc_o    = PCSRC_ALUOUT;
                Retire_o   = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                PCWr_o   = 1'b1;
                PCSrc_o  = PCSRC_JUMP;
                Retire_o = 1'b1;
                state_d  = S_FETCH;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a default-timeout instance for the
// instruction flows and a MEM_TIMEOUT=4 instance for the timeout boundary.
module tb_multicycle_control;

    // Packed control word: {PCWr,PCWrCond,IorD,MemRd,MemWr,IRWr,MemtoReg,
    //                       RegWr,RegDst,ALUSrcA,PCSrc[1:0],ALUSrcB[1:0],ALUOp[1:0],Retire}
    localparam logic [16:0] C_PCWR   = 17'h1 << 16;
    localparam logic [16:0] C_PCWRC  = 17'h1 << 15;
    localparam logic [16:0] C_IORD   = 17'h1 << 14;
    localparam logic [16:0] C_MEMRD  = 17'h1 << 13;
    localparam logic [16:0] C_MEMWR  = 17'h1 << 12;
    localparam logic [16:0] C_IRWR   = 17'h1 << 11;
    localparam logic [16:0] C_M2R    = 17'h1 << 10;
    localparam logic [16:0] C_REGWR  = 17'h1 << 9;
    localparam logic [16:0] C_REGDST = 17'h1 << 8;
    localparam logic [16:0] C_SRCA   = 17'h1 << 7;
    localparam logic [16:0] C_PCS01  = 17'h1 << 5;
    localparam logic [16:0] C_PCS10  = 17'h2 << 5;
    localparam logic [16:0] C_B01    = 17'h1 << 3;
    localparam logic [16:0] C_B10    = 17'h2 << 3;
    localparam logic [16:0] C_B11    = 17'h3 << 3;
    localparam logic [16:0] C_OP01   = 17'h1 << 1;
    localparam logic [16:0] C_OP10   = 17'h2 << 1;
    localparam logic [16:0] C_RET    = 17'h1;

    // State encodings
    localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3,
                           MEMRD = 4'd4, MEMWB = 4'd5, MEMWR = 4'd6, EXEC = 4'd7,
                           RWB = 4'd8, IEXEC = 4'd9, IWB = 4'd10, BRANCH = 4'd11,
                           JUMP = 4'd12, ERROR = 4'd13;

    localparam logic [5:0] ADD = 6'b000000, ADDI = 6'b001000, LW = 6'b100011,
                           SW = 6'b101011, BEQ = 6'b000100, J = 6'b000010, BAD = 6'b111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default-timeout DUT
    logic rst, ack;
    logic [5:0] op;
    logic pcwr, pcwrc, iord, memrd, memwr, irwr, m2r, regwr, regdst, srca, ret, ill, tmo;
    logic [1:0] pcsrc, srcb, aluop;
    logic [3:0] st;
    logic [16:0] ctrl;
    assign ctrl = {pcwr, pcwrc, iord, memrd, memwr, irwr, m2r, regwr, regdst, srca,
                   pcsrc, srcb, aluop, ret};

    multicycle_control dut (
        .clk_i(clk), .rst_i(rst), .Op_i(op), .Mem_ack_i(ack),
        .PCWr_o(pcwr), .PCWrCond_o(pcwrc), .IorD_o(iord), .MemRd_o(memrd),
        .MemWr_o(memwr), .IRWr_o(irwr), .MemtoReg_o(m2r), .RegWr_o(regwr),
        .RegDst_o(regdst), .ALUSrcA_o(srca), .PCSrc_o(pcsrc), .ALUSrcB_o(srcb),
        .ALUOp_o(aluop), .Retire_o(ret), .Illegal_o(ill), .Timeout_o(tmo), .State_o(st)
    );

    // MEM_TIMEOUT=4 DUT
    logic rst4, ack4;
    logic [5:0] op4;
    logic pcwr4, pcwrc4, iord4, memrd4, memwr4, irwr4, m2r4, regwr4, regdst4, srca4, ret4, ill4, tmo4;
    logic [1:0] pcsrc4, srcb4, aluop4;
    logic [3:0] st4;
    logic [16:0] ctrl4;
    assign ctrl4 = {pcwr4, pcwrc4, iord4, memrd4, memwr4, irwr4, m2r4, regwr4, regdst4, srca4,
                    pcsrc4, srcb4, aluop4, ret4};

    multicycle_control #(.MEM_TIMEOUT(4)) dut4 (
        .clk_i(clk), .rst_i(rst4), .Op_i(op4), .Mem_ack_i(ack4),
        .PCWr_o(pcwr4), .PCWrCond_o(pcwrc4), .IorD_o(iord4), .MemRd_o(memrd4),
        .MemWr_o(memwr4), .IRWr_o(irwr4), .MemtoReg_o(m2r4), .RegWr_o(regwr4),
        .RegDst_o(regdst4), .ALUSrcA_o(srca4), .PCSrc_o(pcsrc4), .ALUSrcB_o(srcb4),
        .ALUOp_o(aluop4), .Retire_o(ret4), .Illegal_o(ill4), .Timeout_o(tmo4), .State_o(st4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full check of the default DUT: state, control word, flags
    task automatic chk_all(input string tag, input logic [3:0] es, input logic [16:0] ec,
                           input logic ei, input logic et);
        chk({tag, ".state"}, {28'h0, st}, {28'h0, es});
        chk({tag, ".ctrl"}, {15'h0, ctrl}, {15'h0, ec});
        chk({tag, ".flags"}, {30'h0, ill, tmo}, {30'h0, ei, et});
    endtask

    task automatic chk4(input string tag, input logic [3:0] es, input logic [16:0] ec,
                        input logic ei, input logic et);
        chk({tag, ".state"}, {28'h0, st4}, {28'h0, es});
        chk({tag, ".ctrl"}, {15'h0, ctrl4}, {15'h0, ec});
        chk({tag, ".flags"}, {30'h0, ill4, tmo4}, {30'h0, ei, et});
    endtask

    // Advance to the next negedge, drive inputs, let combinational outputs settle
    task automatic step(input logic [5:0] o, input logic a);
        @(negedge clk);
        op = o; ack = a;
        #1;
    endtask

    task automatic step4(input logic [5:0] o, input logic a);
        @(negedge clk);
        op4 = o; ack4 = a;
        #1;
    endtask

    initial begin
        rst = 1'b1; ack = 1'b0; op = ADD;
        rst4 = 1'b1; ack4 = 1'b0; op4 = SW;
        repeat (2) @(negedge clk);
        #1;
        chk_all("reset", IDLE, 17'h0, 1'b0, 1'b0);

        // add: IDLE, FETCH(ack), DECODE, EXEC, RWB, FETCH
        @(negedge clk); rst = 1'b0; #1;
        chk_all("add.idle", IDLE, 17'h0, 1'b0, 1'b0);
        step(ADD, 1'b1); chk_all("add.fetch", FETCH, C_MEMRD | C_B01 | C_IRWR | C_PCWR, 1'b0, 1'b0);
        step(ADD, 1'b1); chk_all("add.decode", DECODE, C_B11, 1'b0, 1'b0);  // ack ignored here
        step(ADD, 1'b0); chk_all("add.exec", EXEC, C_SRCA | C_OP10, 1'b0, 1'b0);
        step(ADD, 1'b0); chk_all("add.rwb", RWB, C_REGDST | C_REGWR | C_RET, 1'b0, 1'b0);
        step(LW, 1'b0);  chk_all("add.fetch2", FETCH, C_MEMRD | C_B01, 1'b0, 1'b0);

        // lw: FETCH held one more cycle without ack, then ack; MEMRD ack after 3 waits
        step(LW, 1'b1); chk_all("lw.fetch", FETCH, C_MEMRD | C_B01 | C_IRWR | C_PCWR, 1'b0, 1'b0);
        step(LW, 1'b0); chk_all("lw.decode", DECODE, C_B11, 1'b0, 1'b0);
        step(LW, 1'b0); chk_all("lw.memadr", MEMADR, C_SRCA | C_B10, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(LW, 1'b0); chk_all("lw.memrd_wait", MEMRD, C_MEMRD | C_IORD, 1'b0, 1'b0);
        end
        step(LW, 1'b1); chk_all("lw.memrd_ack", MEMRD, C_MEMRD | C_IORD, 1'b0, 1'b0);
        step(LW, 1'b0); chk_all("lw.memwb", MEMWB, C_M2R | C_REGWR | C_RET, 1'b0, 1'b0);
        step(SW, 1'b1); chk_all("lw.fetch_end", FETCH, C_MEMRD | C_B01 | C_IRWR | C_PCWR, 1'b0, 1'b0);

        // sw: ack on first MEMWR cycle retires
        step(SW, 1'b0); chk_all("sw.decode", DECODE, C_B11, 1'b0, 1'b0);
        step(SW, 1'b0); chk_all("sw.memadr", MEMADR, C_SRCA | C_B10, 1'b0, 1'b0);
        step(SW, 1'b1); chk_all("sw.memwr", MEMWR, C_MEMWR | C_IORD | C_RET, 1'b0, 1'b0);
        step(BEQ, 1'b1); chk_all("sw.fetch", FETCH, C_MEMRD | C_B01 | C_IRWR | C_PCWR, 1'b0, 1'b0);

        // beq
        step(BEQ, 1'b0); chk_all("beq.decode", DECODE, C_B11, 1'b0, 1'b0);
        step(BEQ, 1'b0); chk_all("beq.branch", BRANCH, C_SRCA | C_OP01 | C_PCWRC | C_PCS01 | C_RET, 1'b0, 1'b0);
        step(J, 1'b1);   chk_all("j.fetch", FETCH, C_MEMRD | C_B01 | C_IRWR | C_PCWR, 1'b0, 1'b0);

        // j
        step(J, 1'b0); chk_all("j.decode", DECODE, C_B11, 1'b0, 1'b0);
        step(J, 1'b0); chk_all("j.jump", JUMP, C_PCWR | C_PCS10 | C_RET, 1'b0, 1'b0);
        step(ADDI, 1'b1); chk_all("addi.fetch", FETCH, C_MEMRD | C_B01 | C_IRWR | C_PCWR, 1'b0, 1'b0);

        // addi
        step(ADDI, 1'b0); chk_all("addi.decode", DECODE, C_B11, 1'b0, 1'b0);
        step(ADDI, 1'b0); chk_all("addi.iexec", IEXEC, C_SRCA | C_B10, 1'b0, 1'b0);
        step(ADDI, 1'b0); chk_all("addi.iwb", IWB, C_REGWR | C_RET, 1'b0, 1'b0);
        step(BAD, 1'b1);  chk_all("bad.fetch", FETCH, C_MEMRD | C_B01 | C_IRWR | C_PCWR, 1'b0, 1'b0);

        // Illegal opcode: ERROR with sticky flag, held 20 cycles, async reset clears
        step(BAD, 1'b0); chk_all("bad.decode", DECODE, C_B11, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(BAD, (i % 2) == 0); chk_all("bad.error_hold", ERROR, 17'h0, 1'b1, 1'b0);
        end
        @(negedge clk); #2 rst = 1'b1; #1;
        chk_all("bad.async_rst", IDLE, 17'h0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b0; #1;
        chk_all("bad.rel_idle", IDLE, 17'h0, 1'b0, 1'b0);

        // Reset pulsed mid-MEMRD
        step(LW, 1'b1); chk_all("rmid.fetch", FETCH, C_MEMRD | C_B01 | C_IRWR | C_PCWR, 1'b0, 1'b0);
        step(LW, 1'b0); chk_all("rmid.decode", DECODE, C_B11, 1'b0, 1'b0);
        step(LW, 1'b0); chk_all("rmid.memadr", MEMADR, C_SRCA | C_B10, 1'b0, 1'b0);
        step(LW, 1'b0); chk_all("rmid.memrd", MEMRD, C_MEMRD | C_IORD, 1'b0, 1'b0);
        @(negedge clk); #2 rst = 1'b1; #1;
        chk_all("rmid.async_rst", IDLE, 17'h0, 1'b0, 1'b0);
        @(negedge clk); #1;
        chk_all("rmid.held_rst", IDLE, 17'h0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b0; ack = 1'b0; #1;
        chk_all("rmid.rel_idle", IDLE, 17'h0, 1'b0, 1'b0);
        step(LW, 1'b0); chk_all("rmid.fetch2", FETCH, C_MEMRD | C_B01, 1'b0, 1'b0);

        // MEM_TIMEOUT=4: four unacked MEMWR cycles -> ERROR with Timeout
        @(negedge clk); rst4 = 1'b0; #1;
        chk4("tmo.idle", IDLE, 17'h0, 1'b0, 1'b0);
        step4(SW, 1'b1); chk4("tmo.fetch", FETCH, C_MEMRD | C_B01 | C_IRWR | C_PCWR, 1'b0, 1'b0);
        step4(SW, 1'b0); chk4("tmo.decode", DECODE, C_B11, 1'b0, 1'b0);
        step4(SW, 1'b0); chk4("tmo.memadr", MEMADR, C_SRCA | C_B10, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step4(SW, 1'b0); chk4("tmo.memwr_wait", MEMWR, C_MEMWR | C_IORD, 1'b0, 1'b0);
        end
        step4(SW, 1'b1); chk4("tmo.error", ERROR, 17'h0, 1'b0, 1'b1);
        step4(SW, 1'b1); chk4("tmo.error_hold", ERROR, 17'h0, 1'b0, 1'b1);

        // Ack on the 4th MEMWR cycle beats the timeout
        @(negedge clk); rst4 = 1'b1; #1;
        chk4("tmo.rst", IDLE, 17'h0, 1'b0, 1'b0);
        @(negedge clk); rst4 = 1'b0; #1;
        step4(SW, 1'b1); chk4("ack4.fetch", FETCH, C_MEMRD | C_B01 | C_IRWR | C_PCWR, 1'b0, 1'b0);
        step4(SW, 1'b0); chk4("ack4.decode", DECODE, C_B11, 1'b0, 1'b0);
        step4(SW, 1'b0); chk4("ack4.memadr", MEMADR, C_SRCA | C_B10, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step4(SW, 1'b0); chk4("ack4.memwr_wait", MEMWR, C_MEMWR | C_IORD, 1'b0, 1'b0);
        end
        step4(SW, 1'b1); chk4("ack4.memwr_ack", MEMWR, C_MEMWR | C_IORD | C_RET, 1'b0, 1'b0);
        step4(SW, 1'b0); chk4("ack4.fetch2", FETCH, C_MEMRD | C_B01, 1'b0, 1'b0);

        // FETCH times out too after four unacked cycles
        for (int i = 0; i < 3; i++) begin
            step4(SW, 1'b0); chk4("ftmo.fetch_wait", FETCH, C_MEMRD | C_B01, 1'b0, 1'b0);
        end
        step4(SW, 1'b0); chk4("ftmo.error", ERROR, 17'h0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, meaning max cycles a memory-wait state waits for Mem_ack_i; 0 disables the timeout.
REQ-002 clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 Op_i  input  6  opcode of the current instruction-register contents.
REQ-005 Mem_ack_i  input  1  memory completion for the current MemRd_o/MemWr_o request.
REQ-006 PCWr_o, PCWrCond_o, IorD_o, MemRd_o, MemWr_o, IRWr_o, MemtoReg_o, RegWr_o, RegDst_o, ALUSrcA_o  output  1 each  multicycle datapath controls.
REQ-007 PCSrc_o, ALUSrcB_o, ALUOp_o  output  2 each  PC-source, ALU-B-source and ALU-operation selects.
REQ-008 Retire_o  output  1  one-cycle pulse when an instruction completes.
REQ-009 Illegal_o  output  1  sticky illegal-opcode flag; Timeout_o  output  1  sticky memory-timeout flag.
REQ-010 State_o  output  4  current state encoding, for debug.

Function
REQ-011 The block SHALL be a Moore FSM with states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, IEXEC, IWB, BRANCH, JUMP, ERROR.
REQ-012 Any control not listed for a state SHALL be 0. ALUOp_o encodes 00 add, 01 sub, 10 funct-decode.
REQ-013 IDLE: all outputs 0; next state FETCH unconditionally.
REQ-014 FETCH: MemRd_o=1, ALUSrcB_o=01; stay while Mem_ack_i=0; on Mem_ack_i=1 assert IRWr_o=1 and PCWr_o=1 in that cycle and go to DECODE.
REQ-015 DECODE: ALUSrcB_o=11. Next state by opcode: 000000 -> EXEC, 001000 -> IEXEC, 100011 or 101011 -> MEMADR, 000100 -> BRANCH, 000010 -> JUMP, any other -> ERROR with Illegal_o set.
REQ-016 MEMADR: ALUSrcA_o=1, ALUSrcB_o=10. Next state MEMRD for lw, MEMWR for sw.
REQ-017 MEMRD: MemRd_o=1, IorD_o=1; wait for ack, then go to MEMWB.
REQ-018 MEMWB: MemtoReg_o=1, RegWr_o=1; next state FETCH.
REQ-019 MEMWR: MemWr_o=1, IorD_o=1; wait for ack, then go to FETCH.
REQ-020 EXEC: ALUSrcA_o=1, ALUOp_o=10; next state RWB.
REQ-021 RWB: RegDst_o=1, RegWr_o=1; next state FETCH.
REQ-022 IEXEC: ALUSrcA_o=1, ALUSrcB_o=10; next state IWB.
REQ-023 IWB: RegWr_o=1; next state FETCH.
REQ-024 BRANCH: ALUSrcA_o=1, ALUOp_o=01, PCWrCond_o=1, PCSrc_o=01; next state FETCH.
REQ-025 JUMP: PCWr_o=1, PCSrc_o=10; next state FETCH.
REQ-026 Retire_o SHALL be 1 in the cycle the FSM leaves MEMWB, MEMWR (with ack), RWB, IWB, BRANCH or JUMP toward FETCH.
REQ-027 Wait counter: reset to 0 on entry to FETCH, MEMRD or MEMWR; increments each cycle with Mem_ack_i=0.
REQ-028 When the counter equals MEM_TIMEOUT-1 and Mem_ack_i=0, the next state SHALL be ERROR with Timeout_o set.
REQ-029 Ack and timeout in the same cycle: ack wins.
REQ-030 Counter width SHALL be clog2(MEM_TIMEOUT+1) and SHALL saturate, never wrap.
REQ-031 Mem_ack_i outside FETCH, MEMRD and MEMWR SHALL be ignored.
REQ-032 ERROR: all datapath controls 0; FSM stays in ERROR until reset; flags remain set.

Reset
REQ-033 rst_i=1 SHALL immediately force IDLE, clear the counter, Illegal_o and Timeout_o, and drive all outputs to 0, including during any wait state.
REQ-034 Release of reset SHALL resume with IDLE for exactly one cycle, then FETCH.

Structure
REQ-035 Opcode constants, ALUOp/PCSrc/ALUSrcB encodings and the state enumeration SHALL reside in shared package cpu_ctrl_pkg.
REQ-036 The opcode-to-next-state decode SHALL be sub-module op_dispatch (combinational); the FSM, counter and flags stay in the top.

Verification
REQ-037 add (Op 000000), ack on the first FETCH cycle -> states IDLE, FETCH, DECODE, EXEC, RWB, FETCH; RegDst_o=RegWr_o=1 in RWB; Retire_o pulses once.
REQ-038 lw with ack delayed 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with MemtoReg_o=1; total 8 cycles FETCH to FETCH.
REQ-039 beq -> BRANCH shows PCWrCond_o=1, PCSrc_o=01, ALUOp_o=01; j -> JUMP shows PCWr_o=1, PCSrc_o=10.
REQ-040 Op 111111 -> ERROR, Illegal_o=1, held for 20 cycles; asserting rst_i clears it asynchronously.
REQ-041 MEM_TIMEOUT=4, no ack in MEMWR -> ERROR after 4 wait cycles, Timeout_o=1; ack in the 4th cycle -> FETCH with no timeout.
REQ-042 rst_i pulsed mid-MEMRD -> outputs 0 immediately; IDLE, then FETCH after release.
